pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core.
- Each cycle it takes ID-stage register-read requests and EX-stage status, and drives a per-stage stall vector and a flush/redirect to PC/IF.
- Sequences load-use bubbles, multi-cycle EX stalls with timeout, and single-cycle pipeline flushes.
- Keeps a stall performance counter.

Parameters:
REG_ADDR_W, 5, register address width
PC_W, 32, PC / redirect address width
STALL_MAX, 64, EX-stall cycles before timeout abort (>=2)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
id_reg1_read_i  in  1  ID reads operand port 1
id_reg1_addr_i  in  REG_ADDR_W  ID port-1 address
id_reg2_read_i  in  1  ID reads operand port 2
id_reg2_addr_i  in  REG_ADDR_W  ID port-2 address
ex_is_load_i  in  1  instruction in EX is a load
ex_wreg_i  in  1  EX instruction writes a register
ex_wd_i  in  REG_ADDR_W  EX destination register
ex_stallreq_i  in  1  EX multi-cycle op busy (level)
flush_req_i  in  1  flush/redirect request (exception/eret)
flush_pc_i  in  PC_W  redirect target
stall_o  out  6  stall vector {wb,mem,ex,id,if,pc}, bit0=pc
flush_o  out  1  flush all stages, load new_pc_o
new_pc_o  out  PC_W  redirect PC, valid while flush_o=1
state_o  out  2  FSM state (RUN=0, EX_STALL=1, FLUSH=2)
timeout_o  out  1  sticky: EX stall aborted by timeout
stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1, saturating

Behaviour:
- Reset (rst=0, async):
  - state RUN; flush_o=0; new_pc_o=0; timeout_o=0; stall_cnt_o=0; internal stall counter=0.
  - stall_o=0 while rst=0.
- hazard (combinational) = ex_is_load_i & ex_wreg_i & (ex_wd_i!=0) & ((id_reg1_read_i & id_reg1_addr_i==ex_wd_i) | (id_reg2_read_i & id_reg2_addr_i==ex_wd_i)).
  - A disabled read port or register 0 never causes a hazard.
- stall_o is combinational from state and inputs. flush_o, new_pc_o, state_o, timeout_o and stall_cnt_o are registered.
- Priority within a cycle: flush_req_i > ex_stallreq_i > hazard.
- RUN:
  - flush_req_i=1: stall_o=0; latch flush_pc_i into new_pc_o; next FLUSH.
  - else ex_stallreq_i=1: stall_o=6'b001111; internal counter <=1; next EX_STALL.
  - else hazard: stall_o=6'b000111 (bubble into EX); stay RUN. This is exactly one bubble because the load advances to MEM.
  - else stall_o=0.
- EX_STALL:
  - flush_req_i=1: abort stall; stall_o=0; latch PC; next FLUSH; internal counter cleared.
  - else ex_stallreq_i=1 and counter<STALL_MAX: stall_o=6'b001111; counter++.
  - else ex_stallreq_i=1 and counter==STALL_MAX: stall_o=0; timeout_o<=1 (sticky until reset); next RUN.
  - else (ex_stallreq_i=0): stall_o = hazard ? 6'b000111 : 0; next RUN.
- FLUSH:
  - flush_o=1 for exactly this cycle; stall_o=0.
  - Next RUN, unless flush_req_i=1 again: relatch flush_pc_i, stay FLUSH (flush_o stays 1 another cycle).
  - Hazard and ex_stallreq_i are ignored in FLUSH.
  - flush_o=0 in all other states. new_pc_o holds its last value outside FLUSH.
- stall_cnt_o:
  - Increments on each clk edge where stall_o[0]=1.
  - Saturates at all-ones; never wraps.
- Mid-operation reset: any state returns to RUN immediately; stall and flush drop asynchronously.

Test Plan:
1. Load-use: ex_is_load_i=1, ex_wreg_i=1, ex_wd_i=5, id_reg1_read_i=1, id_reg1_addr_i=5 for one cycle -> stall_o=6'b000111 that cycle; state_o stays 0; stall_cnt_o=1 next cycle. Repeat with ex_wd_i=0, or with id_reg1_read_i=0 -> stall_o=0.
2. EX multi-cycle: ex_stallreq_i=1 for 10 cycles -> stall_o=6'b001111 for all 10; state_o=1 from the 2nd cycle; after drop, stall_o=0 and state_o=0; stall_cnt_o=10.
3. Timeout: STALL_MAX=64, ex_stallreq_i held high -> stall_o=6'b001111 for 64 cycles, 0 on the 65th; timeout_o=1 after that edge and stays 1; state_o returns to 0.
4. Flush priority: in EX_STALL assert flush_req_i=1 with flush_pc_i=32'hBFC00380 and a concurrent hazard -> stall_o=0 that cycle; next cycle flush_o=1, new_pc_o=32'hBFC00380, state_o=2; following cycle flush_o=0, state_o=0.
5. Back-to-back flush: flush_req_i high two consecutive cycles with PCs 32'h100 then 32'h200 -> flush_o high two cycles, new_pc_o=32'h100 then 32'h200.
6. Async reset mid-EX_STALL: drive rst=0 between clock edges -> stall_o=0, flush_o=0, state_o=0, stall_cnt_o=0, timeout_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage MIPS core: load-use bubbles, multi-cycle EX
// stalls with timeout abort, single-cycle flush/redirect, and a stall counter.
module pipe_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned STALL_MAX  = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_stallreq_i,
  input  logic                  flush_req_i,
  input  logic [PC_W-1:0]       flush_pc_i,
  output logic [5:0]            stall_o,
  output logic                  flush_o,
  output logic [PC_W-1:0]       new_pc_o,
  output logic [1:0]            state_o,
  output logic                  timeout_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int unsigned TW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_HAZ = 6'b000111;

  state_t          r_state;
  logic            r_flush;
  logic [PC_W-1:0] r_new_pc;
  logic            r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [TW-1:0]   r_ex_cnt;

  state_t          w_next_state;
  logic [5:0]      w_stall;
  logic [TW-1:0]   w_ex_cnt_nxt;
  logic            w_timeout_set;
  logic            w_latch_pc;
  logic            w_hazard;

  assign w_hazard = ex_is_load_i & ex_wreg_i & (ex_wd_i != '0) &
                    ((id_reg1_read_i & (id_reg1_addr_i == ex_wd_i)) |
                     (id_reg2_read_i & (id_reg2_addr_i == ex_wd_i)));

  always_comb begin
    w_next_state  = r_state;
    w_stall       = '0;
    w_ex_cnt_nxt  = r_ex_cnt;
    w_timeout_set = 1'b0;
    w_latch_pc    = 1'b0;
    case (r_state)
      RUN: begin
        if (flush_req_i) begin
          w_latch_pc   = 1'b1;
          w_next_state = FLUSH;
        end else if (ex_stallreq_i) begin
          w_stall      = STALL_EX;
          w_ex_cnt_nxt = TW'(1);
          w_next_state = EX_STALL;
        end else if (w_hazard) begin
          w_stall = STALL_HAZ;
        end
      end
      EX_STALL: begin
        if (flush_req_i) begin
          w_latch_pc   = 1'b1;
          w_ex_cnt_nxt = '0;
          w_next_state = FLUSH;
        end else if (ex_stallreq_i && (r_ex_cnt < TW'(STALL_MAX))) begin
          w_stall      = STALL_EX;
          w_ex_cnt_nxt = r_ex_cnt + 1'b1;
        end else if (ex_stallreq_i) begin
          w_timeout_set = 1'b1;
          w_next_state  = RUN;
        end else begin
          w_stall      = w_hazard ? STALL_HAZ : 6'b000000;
          w_next_state = RUN;
        end
      end
      FLUSH: begin
        if (flush_req_i) begin
          w_latch_pc   = 1'b1;
          w_next_state = FLUSH;
        end else begin
          w_next_state = RUN;
        end
      end
      default: w_next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_flush     <= 1'b0;
      r_new_pc    <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_ex_cnt    <= '0;
    end else begin
      r_state  <= w_next_state;
      // flush_o is high for exactly the cycles spent in FLUSH
      r_flush  <= (w_next_state == FLUSH);
      r_ex_cnt <= w_ex_cnt_nxt;
      if (w_latch_pc)
        r_new_pc <= flush_pc_i;
      if (w_timeout_set)
        r_timeout <= 1'b1;
      if (w_stall[0] && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_o     = rst ? w_stall : 6'b000000;
  assign flush_o     = r_flush;
  assign new_pc_o    = r_new_pc;
  assign state_o     = r_state;
  assign timeout_o   = r_timeout;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, EX stall, timeout, flush priority,
// back-to-back flush, counter saturation and asynchronous reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_reg1_read_i;
  logic [4:0]  id_reg1_addr_i;
  logic        id_reg2_read_i;
  logic [4:0]  id_reg2_addr_i;
  logic        ex_is_load_i;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic        ex_stallreq_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [1:0]  state_o;
  logic        timeout_o;
  logic [15:0] stall_cnt_o;

  logic [5:0]  sat_stall;
  logic        sat_flush;
  logic [31:0] sat_new_pc;
  logic [1:0]  sat_state;
  logic        sat_timeout;
  logic [2:0]  sat_cnt;

  int unsigned n_chk;
  int unsigned n_fail;
  int unsigned exp_cnt;

  pipe_ctrl #(
    .REG_ADDR_W(5),
    .PC_W      (32),
    .STALL_MAX (64),
    .CNT_W     (16)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .id_reg1_read_i(id_reg1_read_i),
    .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i),
    .id_reg2_addr_i(id_reg2_addr_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_wreg_i     (ex_wreg_i),
    .ex_wd_i       (ex_wd_i),
    .ex_stallreq_i (ex_stallreq_i),
    .flush_req_i   (flush_req_i),
    .flush_pc_i    (flush_pc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .state_o       (state_o),
    .timeout_o     (timeout_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Narrow-counter instance sharing all stimulus, used to observe saturation
  pipe_ctrl #(
    .REG_ADDR_W(5),
    .PC_W      (32),
    .STALL_MAX (64),
    .CNT_W     (3)
  ) u_sat (
    .clk           (clk),
    .rst           (rst),
    .id_reg1_read_i(id_reg1_read_i),
    .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i),
    .id_reg2_addr_i(id_reg2_addr_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_wreg_i     (ex_wreg_i),
    .ex_wd_i       (ex_wd_i),
    .ex_stallreq_i (ex_stallreq_i),
    .flush_req_i   (flush_req_i),
    .flush_pc_i    (flush_pc_i),
    .stall_o       (sat_stall),
    .flush_o       (sat_flush),
    .new_pc_o      (sat_new_pc),
    .state_o       (sat_state),
    .timeout_o     (sat_timeout),
    .stall_cnt_o   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_reg1_read_i = 1'b0;
    id_reg1_addr_i = '0;
    id_reg2_read_i = 1'b0;
    id_reg2_addr_i = '0;
    ex_is_load_i   = 1'b0;
    ex_wreg_i      = 1'b0;
    ex_wd_i        = '0;
    ex_stallreq_i  = 1'b0;
    flush_req_i    = 1'b0;
    flush_pc_i     = '0;
  endtask

  task automatic set_hazard();
    ex_is_load_i   = 1'b1;
    ex_wreg_i      = 1'b1;
    ex_wd_i        = 5'd5;
    id_reg1_read_i = 1'b1;
    id_reg1_addr_i = 5'd5;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    exp_cnt = 0;
    idle();
    rst           = 1'b0;
    ex_stallreq_i = 1'b1;
    #3;
    check("rst_stall", {26'd0, stall_o}, 32'h0);
    #4;
    check("rst_state", {30'd0, state_o}, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_newpc", new_pc_o, 32'h0);
    check("rst_tmo",   {31'd0, timeout_o}, 32'd0);
    check("rst_cnt",   {16'd0, stall_cnt_o}, 32'd0);
    idle();
    #1 rst = 1'b1;
    tick();

    // load-use bubble and non-hazard variants
    set_hazard();
    #2 check("lu_stall", {26'd0, stall_o}, 32'h07);
    tick(); exp_cnt++;
    check("lu_state", {30'd0, state_o}, 32'd0);
    check("lu_cnt", {16'd0, stall_cnt_o}, exp_cnt);
    ex_wd_i = 5'd0; id_reg1_addr_i = 5'd0;
    #2 check("lu_r0", {26'd0, stall_o}, 32'h0);
    ex_wd_i = 5'd5; id_reg1_addr_i = 5'd5; id_reg1_read_i = 1'b0;
    #2 check("lu_rd_off", {26'd0, stall_o}, 32'h0);
    id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd5;
    #2 check("lu_port2", {26'd0, stall_o}, 32'h07);
    tick(); exp_cnt++;
    check("lu_cnt2", {16'd0, stall_cnt_o}, exp_cnt);
    ex_is_load_i = 1'b0;
    #2 check("lu_noload", {26'd0, stall_o}, 32'h0);
    idle();
    tick();

    // 10-cycle multi-cycle EX stall
    for (int i = 0; i < 10; i++) begin
      ex_stallreq_i = 1'b1;
      #2 check("ex_stall", {26'd0, stall_o}, 32'h0F);
      check("ex_state", {30'd0, state_o}, (i == 0) ? 32'd0 : 32'd1);
      tick(); exp_cnt++;
    end
    ex_stallreq_i = 1'b0;
    #2 check("ex_drop_stall", {26'd0, stall_o}, 32'h0);
    tick();
    check("ex_drop_state", {30'd0, state_o}, 32'd0);
    check("ex_cnt", {16'd0, stall_cnt_o}, exp_cnt);

    // timeout after STALL_MAX=64 stall cycles
    ex_stallreq_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #2 check("to_stall", {26'd0, stall_o}, 32'h0F);
      tick(); exp_cnt++;
    end
    #2 check("to_stall65", {26'd0, stall_o}, 32'h0);
    check("to_pre_tmo", {31'd0, timeout_o}, 32'd0);
    tick();
    check("to_tmo", {31'd0, timeout_o}, 32'd1);
    check("to_state", {30'd0, state_o}, 32'd0);
    check("to_cnt", {16'd0, stall_cnt_o}, exp_cnt);
    ex_stallreq_i = 1'b0;
    tick();
    tick();
    check("to_sticky", {31'd0, timeout_o}, 32'd1);

    // flush beats stall and hazard; FLUSH ignores stall/hazard
    ex_stallreq_i = 1'b1;
    tick(); exp_cnt++;
    check("fp_in_ex", {30'd0, state_o}, 32'd1);
    set_hazard();
    flush_req_i = 1'b1;
    flush_pc_i  = 32'hBFC00380;
    #2 check("fp_stall", {26'd0, stall_o}, 32'h0);
    tick();
    check("fp_flush", {31'd0, flush_o}, 32'd1);
    check("fp_newpc", new_pc_o, 32'hBFC00380);
    check("fp_state", {30'd0, state_o}, 32'd2);
    flush_req_i = 1'b0;
    #2 check("fp_flush_stall", {26'd0, stall_o}, 32'h0);
    tick();
    check("fp_flush_off", {31'd0, flush_o}, 32'd0);
    check("fp_state_run", {30'd0, state_o}, 32'd0);
    check("fp_cnt", {16'd0, stall_cnt_o}, exp_cnt);
    idle();
    tick();

    // back-to-back flush
    flush_req_i = 1'b1;
    flush_pc_i  = 32'h100;
    tick();
    check("bb_flush1", {31'd0, flush_o}, 32'd1);
    check("bb_pc1", new_pc_o, 32'h100);
    flush_pc_i = 32'h200;
    tick();
    check("bb_flush2", {31'd0, flush_o}, 32'd1);
    check("bb_pc2", new_pc_o, 32'h200);
    check("bb_state2", {30'd0, state_o}, 32'd2);
    idle();
    tick();
    check("bb_flush_off", {31'd0, flush_o}, 32'd0);
    check("bb_pc_hold", new_pc_o, 32'h200);
    check("bb_state_run", {30'd0, state_o}, 32'd0);

    check("sat_cnt", {29'd0, sat_cnt}, 32'd7);

    // asynchronous reset while in EX_STALL
    ex_stallreq_i = 1'b1;
    tick(); exp_cnt++;
    check("ar_in_ex", {30'd0, state_o}, 32'd1);
    check("ar_pre_cnt", {16'd0, stall_cnt_o}, exp_cnt);
    #2 rst = 1'b0;
    #1;
    check("ar_stall", {26'd0, stall_o}, 32'h0);
    check("ar_flush", {31'd0, flush_o}, 32'd0);
    check("ar_state", {30'd0, state_o}, 32'd0);
    check("ar_cnt",   {16'd0, stall_cnt_o}, 32'd0);
    check("ar_tmo",   {31'd0, timeout_o}, 32'd0);
    check("ar_newpc", new_pc_o, 32'h0);
    idle();
    #1 rst = 1'b1;
    tick();
    check("ar_post_state", {30'd0, state_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
